// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces the mode/add buttons and walks the
// RUN -> SET_H -> SET_M -> SET_S cycle, editing a BCD copy of the live time
// and loading it back into the counters with a one-cycle ld pulse.
module time_set_ctrl #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter logic [15:0] BLINK_DIV = 16'd12500,
  parameter logic [23:0] TIMEOUT   = 24'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_add,
  input  logic [3:0] cur_s0,
  input  logic [3:0] cur_s1,
  input  logic [3:0] cur_m0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_h1,
  output logic [3:0] d_s0,
  output logic [3:0] d_s1,
  output logic [3:0] d_m0,
  output logic [3:0] d_m1,
  output logic [3:0] d_h0,
  output logic [3:0] d_h1,
  output logic       ld,
  output logic [1:0] field,
  output logic       editing,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  // Bit 0 = mode button, bit 1 = add button.
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  lvl;
  logic [1:0]  armed;
  logic [1:0]  press;
  logic [1:0]  fill;
  logic [15:0] db_cnt [2];

  state_t      st;
  logic [23:0] idle_cnt;
  logic [15:0] blink_cnt;

  // BCD pair increment that wraps to 00 once {max_hi,max_lo} is reached.
  function automatic logic [7:0] inc_pair(input logic [3:0] hi, input logic [3:0] lo,
                                          input logic [3:0] max_hi, input logic [3:0] max_lo);
    logic [7:0] r;
    if (hi == max_hi && lo == max_lo) r = 8'h00;
    else if (lo == 4'd9)              r = {4'(hi + 4'd1), 4'd0};
    else                              r = {hi, 4'(lo + 4'd1)};
    return r;
  endfunction

  // Synchronize, debounce and edge-detect both buttons. A button is only armed
  // once it has been seen released after reset, so a button held through reset
  // cannot produce a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      lvl       <= 2'b00;
      armed     <= 2'b00;
      press     <= 2'b00;
      fill      <= 2'd0;
      db_cnt[0] <= 16'd0;
      db_cnt[1] <= 16'd0;
    end else begin
      sync1 <= {btn_add, btn_mode};
      sync2 <= sync1;
      if (fill != 2'd2) fill <= 2'(fill + 2'd1);
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (fill == 2'd2 && !sync2[i] && !lvl[i]) armed[i] <= 1'b1;
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= 16'd0;
        end else if (db_cnt[i] == DB_CYCLES - 16'd1) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= 16'd0;
          press[i]  <= sync2[i] & armed[i];
        end else begin
          db_cnt[i] <= 16'(db_cnt[i] + 16'd1);
        end
      end
    end
  end

  // Edit state machine with idle timeout, blink timer and digit editing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= RUN;
      editing   <= 1'b0;
      ld        <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= 16'd0;
      idle_cnt  <= 24'd0;
      {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0} <= 24'd0;
    end else begin
      ld <= 1'b0;
      if (st != RUN) begin
        if (blink_cnt == BLINK_DIV - 16'd1) begin
          blink     <= ~blink;
          blink_cnt <= 16'd0;
        end else begin
          blink_cnt <= 16'(blink_cnt + 16'd1);
        end
      end
      case (st)
        RUN: begin
          if (press[0]) begin
            st        <= SET_H;
            editing   <= 1'b1;
            idle_cnt  <= 24'd0;
            blink     <= 1'b0;
            blink_cnt <= 16'd0;
            {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0} <=
              {cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0};
          end
        end
        default: begin
          if (press[0]) begin
            idle_cnt  <= 24'd0;
            blink     <= 1'b0;
            blink_cnt <= 16'd0;
            case (st)
              SET_H:   st <= SET_M;
              SET_M:   st <= SET_S;
              default: begin
                st      <= RUN;
                editing <= 1'b0;
                ld      <= 1'b1;
              end
            endcase
          end else if (press[1]) begin
            idle_cnt <= 24'd0;
            case (st)
              SET_H:   {d_h1, d_h0} <= inc_pair(d_h1, d_h0, 4'd2, 4'd3);
              SET_M:   {d_m1, d_m0} <= inc_pair(d_m1, d_m0, 4'd5, 4'd9);
              default: {d_s1, d_s0} <= inc_pair(d_s1, d_s0, 4'd5, 4'd9);
            endcase
          end else if (idle_cnt == TIMEOUT - 24'd1) begin
            st        <= RUN;
            editing   <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= 16'd0;
            idle_cnt  <= 24'd0;
          end else begin
            idle_cnt <= 24'(idle_cnt + 24'd1);
          end
        end
      endcase
    end
  end

  assign field = st;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/blink/timeout settings.
module tb_time_set_ctrl;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_add;
  logic [3:0] cur_s0, cur_s1, cur_m0, cur_m1, cur_h0, cur_h1;
  logic [3:0] d_s0, d_s1, d_m0, d_m1, d_h0, d_h1;
  logic       ld;
  logic [1:0] field;
  logic       editing;
  logic       blink;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned ld_cnt = 0;
  logic [23:0] ld_d = 24'd0;
  logic [23:0] dvec;

  assign dvec = {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0};

  time_set_ctrl #(
    .DB_CYCLES(16'd4),
    .BLINK_DIV(16'd3),
    .TIMEOUT  (24'd100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_add (btn_add),
    .cur_s0  (cur_s0),
    .cur_s1  (cur_s1),
    .cur_m0  (cur_m0),
    .cur_m1  (cur_m1),
    .cur_h0  (cur_h0),
    .cur_h1  (cur_h1),
    .d_s0    (d_s0),
    .d_s1    (d_s1),
    .d_m0    (d_m0),
    .d_m1    (d_m1),
    .d_h0    (d_h0),
    .d_h1    (d_h1),
    .ld      (ld),
    .field   (field),
    .editing (editing),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  // Count ld cycles and capture the load data seen with them.
  always @(negedge clk) begin
    if (ld) begin
      ld_cnt = ld_cnt + 1;
      ld_d   = dvec;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cur(input logic [23:0] v);
    {cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0} = v;
  endtask

  // Raise the buttons (called #1 after an edge); field must hold until edge DB+3.
  task automatic press(input logic m, input logic a);
    logic [1:0] f0;
    f0 = field;
    btn_mode = m;
    btn_add  = a;
    repeat (DB + 2) @(posedge clk);
    #1;
    check("lat_hold", 32'(field), 32'(f0));
    @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    btn_mode = 1'b0;
    btn_add  = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic m, input logic a);
    press(m, a);
    release_btns();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    btn_mode = 1'b1;
    btn_add  = 1'b0;
    set_cur(24'h123456);
    #1;
    check("rst_field", 32'(field), 32'd0);
    check("rst_edit", 32'(editing), 32'd0);
    check("rst_ld", 32'(ld), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_d", 32'(dvec), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    // Mode held across reset release must not count as a press.
    repeat (20) @(posedge clk);
    #1;
    check("held_rst", 32'(field), 32'd0);
    release_btns();
    check("held_rel", 32'(field), 32'd0);

    // Four mode presses, no add: d passes through unchanged.
    set_cur(24'h235958);
    ld_cnt = 0;
    press(1'b1, 1'b0);
    check("f_seth", 32'(field), 32'd1);
    check("edit_on", 32'(editing), 32'd1);
    check("capture", 32'(dvec), 32'h235958);
    check("blink_e0", 32'(blink), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("blink_e2", 32'(blink), 32'd0);
    @(posedge clk);
    #1;
    check("blink_e3", 32'(blink), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("blink_e6", 32'(blink), 32'd0);
    release_btns();
    press(1'b1, 1'b0);
    check("f_setm", 32'(field), 32'd2);
    check("blink_re", 32'(blink), 32'd0);
    release_btns();
    tap(1'b1, 1'b0);
    check("f_sets", 32'(field), 32'd3);
    press(1'b1, 1'b0);
    check("f_run", 32'(field), 32'd0);
    check("ld_hi", 32'(ld), 32'd1);
    check("edit_off", 32'(editing), 32'd0);
    @(posedge clk);
    #1;
    check("ld_lo", 32'(ld), 32'd0);
    release_btns();
    check("ld_cnt1", ld_cnt, 32'd1);
    check("ld_d1", 32'(ld_d), 32'h235958);
    check("d_hold1", 32'(dvec), 32'h235958);

    // Wrap every pair: 23->00, 59->00, 58->59.
    ld_cnt = 0;
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    check("h_wrap", 32'(dvec), 32'h005958);
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    check("m_wrap", 32'(dvec), 32'h000058);
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    tap(1'b1, 1'b0);
    check("ld_cnt2", ld_cnt, 32'd1);
    check("ld_d2", 32'(ld_d), 32'h000059);

    // Low-digit carry in every pair.
    set_cur(24'h090909);
    ld_cnt = 0;
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    tap(1'b1, 1'b0);
    check("ld_cnt3", ld_cnt, 32'd1);
    check("ld_d3", 32'(ld_d), 32'h101010);

    // Add in RUN is ignored.
    tap(1'b0, 1'b1);
    check("run_add_f", 32'(field), 32'd0);
    check("run_add_d", 32'(dvec), 32'h101010);

    // Out-of-range hours captured as-is and incremented normally.
    set_cur(24'h270000);
    ld_cnt = 0;
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    check("oor_h", 32'(dvec), 32'h280000);
    tap(1'b1, 1'b0);
    tap(1'b1, 1'b0);
    tap(1'b1, 1'b0);
    check("ld_d4", 32'(ld_d), 32'h280000);

    // Bounce 1-0-1-0 then steady high: one press, latency from steady edge.
    set_cur(24'h121212);
    ld_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      btn_mode = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      btn_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    check("bounce_f", 32'(field), 32'd0);
    press(1'b1, 1'b0);
    check("bounce_p", 32'(field), 32'd1);
    release_btns();
    check("bounce_1", 32'(field), 32'd1);

    // Idle timeout: TIMEOUT cycles after the entry edge, back to RUN, no ld.
    repeat (87) @(posedge clk);
    #1;
    check("to_pre", 32'(field), 32'd1);
    @(posedge clk);
    #1;
    check("to_run", 32'(field), 32'd0);
    check("to_ld", ld_cnt, 32'd0);
    check("to_d", 32'(dvec), 32'h121212);

    // Simultaneous mode+add in SET_H: mode wins, hours untouched.
    set_cur(24'h123456);
    tap(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both_f", 32'(field), 32'd2);
    check("both_d", 32'(dvec), 32'h123456);
    release_btns();

    // Async reset mid SET_M clears outputs immediately, no ld.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_f", 32'(field), 32'd0);
    check("arst_e", 32'(editing), 32'd0);
    check("arst_d", 32'(dvec), 32'd0);
    check("arst_b", 32'(blink), 32'd0);
    check("arst_ld", 32'(ld), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst_ldc", ld_cnt, 32'd0);
    check("arst_f2", 32'(field), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
